// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types for the instruction-fetch prefetch unit:
//                APB fetch FSM state, NOP encoding and buffer entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0).
    localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

    // Storage width for the PC field of a buffer entry; the top module
    // zero-extends its ADDR_W-bit PC into it (ADDR_W must not exceed this).
    localparam int unsigned RISCV_PC_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic [31:0]           instr;
        logic [RISCV_PC_W-1:0] pc;
        logic                  fault;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/riscv_if_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_if_fifo
//  Description : DEPTH-entry show-ahead FIFO of fetch entries with flush.
//                Head is read straight from storage registers. Push and pop
//                in the same cycle on a full FIFO are allowed.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_if_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned  DEPTH       = 2,
    parameter fetch_entry_t RESET_ENTRY = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output fetch_entry_t               head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q;
    logic [PTR_W-1:0]   rd_q;
    logic [CNT_W-1:0]   count_q;

    // Pointer, occupancy and storage update; flush only rewinds pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= RESET_ENTRY;
            end
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

endmodule
`default_nettype wire

// File: rtl/riscv_if_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_if_prefetch
//  Description : APB instruction-fetch unit with prefetch buffer, sequential
//                PC, and redirect/flush. Optional macro RISCV_IF_PSLVERR_EN
//                records pslverr_i as a per-entry fault and halts fetch after
//                a fault until the next redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_if_prefetch
    import riscv_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              psel_o,
    output logic              penable_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              pwrite_o,
    output logic [31:0]       pwdata_o,
    input  logic              pready_i,
    input  logic [31:0]       prdata_i,
    input  logic              pslverr_i,
    input  logic              ex_if_redirect_i,
    input  logic [ADDR_W-1:0] ex_if_pc_i,
    output logic              if_dec_valid_o,
    output logic [31:0]       if_dec_instr_o,
    output logic [ADDR_W-1:0] if_dec_pc_o,
    output logic              if_dec_fault_o,
    input  logic              dec_if_ready_i
);

    localparam int unsigned  CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned  OCC_W = CNT_W + 1;
    localparam fetch_entry_t RESET_ENTRY = '{instr: RISCV_NOP,
                                             pc:    RISCV_PC_W'(RESET_PC),
                                             fault: 1'b0};

    apb_state_t        state_q;
    logic              psel_q, penable_q;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] paddr_q;
    logic              kill_q, kill_d;
    logic              stop_q, stop_d;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      head, push_entry;
    logic              completing, in_flight, push, pop, credit, fault_in;
    logic [OCC_W-1:0]  occ_next;

`ifdef RISCV_IF_PSLVERR_EN
    assign fault_in       = pslverr_i;
    assign if_dec_fault_o = if_dec_valid_o & head.fault;
    logic unused_bits;
    assign unused_bits = ^{head.pc, ex_if_pc_i[1:0]};
`else
    assign fault_in       = 1'b0;
    assign if_dec_fault_o = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{head.pc, head.fault, ex_if_pc_i[1:0], pslverr_i};
`endif

    // Handshakes, credit and next-state of PC / kill / fault-stop.
    always_comb begin
        completing = (state_q == ST_ACCESS) && pready_i;
        // A transfer that is still on the bus after this edge.
        in_flight  = (state_q == ST_SETUP) || ((state_q == ST_ACCESS) && !pready_i);
        push       = completing && !kill_q && !ex_if_redirect_i;
        pop        = if_dec_valid_o && dec_if_ready_i && !ex_if_redirect_i;
        occ_next   = ex_if_redirect_i ? '0
                   : OCC_W'(count) + OCC_W'(push) - OCC_W'(pop);
        stop_d     = ex_if_redirect_i ? 1'b0 : (stop_q | (push & fault_in));
        credit     = ((occ_next + OCC_W'(in_flight)) < OCC_W'(DEPTH)) && !stop_d;

        fetch_pc_d = fetch_pc_q;
        if (ex_if_redirect_i) begin
            fetch_pc_d = {ex_if_pc_i[ADDR_W-1:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end

        // A redirect that lands mid-transfer marks it for discard; the mark
        // clears when that transfer finishes on the bus.
        kill_d = kill_q;
        if (ex_if_redirect_i && in_flight) begin
            kill_d = 1'b1;
        end else if (completing) begin
            kill_d = 1'b0;
        end

        push_entry.instr = fault_in ? RISCV_NOP : prdata_i;
        push_entry.pc    = RISCV_PC_W'(paddr_q);
        push_entry.fault = fault_in;
    end

    // APB fetch FSM with registered psel/penable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (credit) begin
                        state_q <= ST_SETUP;
                        psel_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end
                ST_ACCESS: begin
                    if (pready_i) begin
                        state_q   <= credit ? ST_SETUP : ST_IDLE;
                        psel_q    <= credit;
                        penable_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    // Fetch PC, bus address and control flags. The bus address only follows
    // the fetch PC between transfers so it stays frozen across SETUP/ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            paddr_q    <= RESET_PC;
            kill_q     <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
            stop_q     <= stop_d;
            if ((state_q == ST_IDLE) || completing) begin
                paddr_q <= fetch_pc_d;
            end
        end
    end

    riscv_if_fifo #(
        .DEPTH       (DEPTH),
        .RESET_ENTRY (RESET_ENTRY)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (ex_if_redirect_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    assign psel_o         = psel_q;
    assign penable_o      = penable_q;
    assign paddr_o        = paddr_q;
    assign pwrite_o       = 1'b0;
    assign pwdata_o       = '0;
    assign if_dec_valid_o = (count != '0);
    assign if_dec_instr_o = if_dec_valid_o ? head.instr : RISCV_NOP;
    assign if_dec_pc_o    = head.pc[ADDR_W-1:0];

endmodule
`default_nettype wire
